// File: rtl/simon_pkg.sv
// Shared types, default sizing constants and the pattern symbol-slice helper
// for the Simon checker, game controller and pattern generator.
package simon_pkg;

  localparam int unsigned SIMON_SYM_W       = 4;
  localparam int unsigned SIMON_MAX_LEN     = 10;
  localparam int unsigned SIMON_TIMEOUT_CYC = 0;

  // Upper bounds for the generic slice helper; MAX_LEN*SYM_W must fit PAT_W_MAX.
  localparam int unsigned SIMON_SYM_W_MAX = 32;
  localparam int unsigned SIMON_PAT_W_MAX = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_PASS,
    S_FAIL,
    S_WIN
  } simon_state_e;

  // Returns symbol idx of a packed pattern (LSB-aligned); the caller truncates
  // the result to its own symbol width.
  function automatic logic [SIMON_SYM_W_MAX-1:0] sym_slice(
    input logic [SIMON_PAT_W_MAX-1:0] pat,
    input int unsigned                idx,
    input int unsigned                sym_w
  );
    logic [SIMON_PAT_W_MAX-1:0] shifted;
    shifted = pat >> (idx * sym_w);
    return shifted[SIMON_SYM_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/simon_seq_checker_timer.sv
// Per-press timeout counter: counts enabled cycles since the last clear and
// flags the final allowed cycle. TIMEOUT_CYC=0 disables expiry and the
// counter simply saturates.
module simon_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [TW-1:0] count;

  // Saturating cycle counter, cleared on request or reset.
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TW'(1);
    end
  end

  // Expiry is the last cycle a press may still arrive in.
  always_comb begin
    expire = 1'b0;
    if (TIMEOUT_CYC > 0) begin
      expire = enable && (count == LAST);
    end
  end

endmodule

// File: rtl/simon_seq_checker.sv
// Simon input checker: compares player presses against the stored pattern,
// tracks the press index and completed-round level, and reports the round
// result as Moore-decoded one-cycle pulses.
module simon_seq_checker
  import simon_pkg::*;
#(
  parameter int unsigned SYM_W       = SIMON_SYM_W,
  parameter int unsigned MAX_LEN     = SIMON_MAX_LEN,
  parameter int unsigned LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned TIMEOUT_CYC = SIMON_TIMEOUT_CYC
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [MAX_LEN*SYM_W-1:0] pattern,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         in_sym,
  output logic                     busy,
  output logic [LEN_W-1:0]         index,
  output logic [LEN_W-1:0]         level,
  output logic                     result_valid,
  output logic                     result_correct,
  output logic                     game_over,
  output logic                     win
);

  simon_state_e     state_q, state_d;
  logic [LEN_W-1:0] index_q, index_d;
  logic [LEN_W-1:0] level_q, level_d;
  logic             tmr_clear;
  logic             tmr_expire;
  logic [SYM_W-1:0] exp_sym;

  assign exp_sym = SYM_W'(sym_slice(SIMON_PAT_W_MAX'(pattern), int'(index_q), SYM_W));

  simon_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock (clock),
    .resetn(resetn),
    .clear (tmr_clear),
    .enable(state_q == S_WAIT_IN),
    .expire(tmr_expire)
  );

  // State, index and level registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      index_q <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      level_q <= level_d;
    end
  end

  // Next state; priority in WAIT_IN is start, then press, then timeout.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    level_d   = level_q;
    tmr_clear = (state_q != S_WAIT_IN);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_IN;
          index_d = '0;
        end
      end
      S_WAIT_IN: begin
        if (start) begin
          index_d   = '0;
          tmr_clear = 1'b1;
        end else if (in_valid) begin
          if (in_sym != exp_sym) begin
            state_d = S_FAIL;
          end else if (index_q == level_q) begin
            state_d = (level_q == LEN_W'(MAX_LEN - 1)) ? S_WIN : S_PASS;
          end else begin
            index_d   = index_q + LEN_W'(1);
            tmr_clear = 1'b1;
          end
        end else if (tmr_expire) begin
          state_d = S_FAIL;
        end
      end
      S_PASS: begin
        state_d = S_IDLE;
        index_d = '0;
        level_d = level_q + LEN_W'(1);
      end
      S_FAIL, S_WIN: begin
        state_d = S_IDLE;
        index_d = '0;
        level_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        index_d = '0;
        level_d = '0;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    busy           = (state_q == S_WAIT_IN);
    result_valid   = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_WIN);
    result_correct = (state_q == S_PASS) || (state_q == S_WIN);
    game_over      = (state_q == S_FAIL);
    win            = (state_q == S_WIN);
    index          = index_q;
    level          = level_q;
  end

endmodule

// File: tb/tb_simon_seq_checker.sv
// Directed bench for simon_seq_checker with SYM_W=4, MAX_LEN=4, TIMEOUT_CYC=8.
module tb_simon_seq_checker;

  localparam int unsigned SYM_W   = 4;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned TMO     = 8;

  logic                     clock = 1'b0;
  logic                     resetn = 1'b0;
  logic                     start = 1'b0;
  logic [MAX_LEN*SYM_W-1:0] pattern = 16'b1000_0010_0100_0001;
  logic                     in_valid = 1'b0;
  logic [SYM_W-1:0]         in_sym = '0;
  logic                     busy, result_valid, result_correct, game_over, win;
  logic [LEN_W-1:0]         index, level;

  // {busy, result_valid, result_correct, game_over, win}
  logic [4:0] flags;
  assign flags = {busy, result_valid, result_correct, game_over, win};

  logic [SYM_W-1:0] syms [MAX_LEN] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};

  int passed = 0;
  int total  = 0;

  simon_seq_checker #(
    .SYM_W(SYM_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W(LEN_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .pattern(pattern),
    .in_valid(in_valid), .in_sym(in_sym), .busy(busy), .index(index),
    .level(level), .result_valid(result_valid), .result_correct(result_correct),
    .game_over(game_over), .win(win)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [SYM_W-1:0] s);
    in_valid = 1'b1;
    in_sym   = s;
    tick();
    in_valid = 1'b0;
    in_sym   = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    total++;
    if ({flags, index, level} !== '0) $display("FAIL reset_state: got flags=%b index=%0d level=%0d, want all 0", flags, index, level);
    else passed++;
    resetn = 1'b1;
  endtask

  task automatic test_pass();
    do_start();
    total++;
    if (flags !== 5'b10000 || index !== 0) $display("FAIL pass_start: got flags=%b index=%0d, want 10000/0", flags, index);
    else passed++;
    press(4'b0001);
    total++;
    if (flags !== 5'b01100) $display("FAIL pass_result: got flags=%b, want 01100", flags);
    else passed++;
    tick();
    total++;
    if (flags !== 5'b00000 || level !== 1 || index !== 0) $display("FAIL pass_after: got flags=%b level=%0d index=%0d, want 00000/1/0", flags, level, index);
    else passed++;
  endtask

  task automatic test_fail();
    do_start();
    press(4'b0001);
    total++;
    if (flags !== 5'b10000 || index !== 1) $display("FAIL fail_mid: got flags=%b index=%0d, want 10000/1", flags, index);
    else passed++;
    press(4'b1000);
    total++;
    if (flags !== 5'b01010) $display("FAIL fail_result: got flags=%b, want 01010", flags);
    else passed++;
    tick();
    total++;
    if (flags !== 5'b00000 || level !== 0) $display("FAIL fail_after: got flags=%b level=%0d, want 00000/0", flags, level);
    else passed++;
  endtask

  task automatic test_win();
    for (int lvl = 0; lvl < int'(MAX_LEN); lvl++) begin
      do_start();
      for (int k = 0; k <= lvl; k++) press(syms[k]);
      total++;
      if (lvl < int'(MAX_LEN) - 1) begin
        if (flags !== 5'b01100) $display("FAIL win_round%0d: got flags=%b, want 01100", lvl, flags);
        else passed++;
      end else begin
        if (flags !== 5'b01101) $display("FAIL win_final: got flags=%b, want 01101", flags);
        else passed++;
      end
      tick();
      total++;
      if (level !== LEN_W'((lvl < int'(MAX_LEN) - 1) ? lvl + 1 : 0) || flags !== 5'b00000)
        $display("FAIL win_level%0d: got level=%0d flags=%b, want level=%0d flags=00000",
                 lvl, level, flags, (lvl < int'(MAX_LEN) - 1) ? lvl + 1 : 0);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    do_start();
    for (int c = 0; c < int'(TMO); c++) begin
      total++;
      if (flags !== 5'b10000) $display("FAIL timeout_wait%0d: got flags=%b, want 10000", c, flags);
      else passed++;
      tick();
    end
    total++;
    if (flags !== 5'b01010) $display("FAIL timeout_fire: got flags=%b, want 01010", flags);
    else passed++;
    tick();
  endtask

  task automatic test_press_at_limit();
    do_start();
    repeat (TMO - 1) tick();
    press(4'b0001);
    total++;
    if (flags !== 5'b01100) $display("FAIL limit_press: got flags=%b, want 01100", flags);
    else passed++;
    tick();
    total++;
    if (level !== 1) $display("FAIL limit_level: got level=%0d, want 1", level);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_start();
    press(4'b0001);
    press(4'b0100);
    tick();
    do_start();
    press(4'b0001);
    total++;
    if (level !== 2 || index !== 1 || flags !== 5'b10000) $display("FAIL rstmid_setup: got level=%0d index=%0d flags=%b, want 2/1/10000", level, index, flags);
    else passed++;
    resetn = 1'b0;
    tick();
    total++;
    if ({flags, index, level} !== '0) $display("FAIL rstmid_state: got flags=%b index=%0d level=%0d, want all 0", flags, index, level);
    else passed++;
    resetn = 1'b1;
  endtask

  task automatic test_start_with_press();
    do_start();
    press(4'b0001);
    tick();
    do_start();
    press(4'b0001);
    start = 1'b1;
    press(4'b0100);
    start = 1'b0;
    total++;
    if (index !== 0 || level !== 1 || flags !== 5'b10000) $display("FAIL startpress: got index=%0d level=%0d flags=%b, want 0/1/10000", index, level, flags);
    else passed++;
    tick();
    total++;
    if (flags !== 5'b10000) $display("FAIL startpress_after: got flags=%b, want 10000", flags);
    else passed++;
    press(4'b1000);
    tick();
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 3; i++) begin
      press(syms[i]);
      total++;
      if (flags !== 5'b00000 || index !== 0 || level !== 0) $display("FAIL idle_ignore%0d: got flags=%b index=%0d level=%0d, want 00000/0/0", i, flags, index, level);
      else passed++;
    end
  endtask

  task automatic test_restart();
    do_start();
    press(4'b0001);
    tick();
    do_start();
    press(4'b0001);
    for (int r = 0; r < 2; r++) begin
      do_start();
      total++;
      if (index !== 0 || level !== 1 || flags !== 5'b10000) $display("FAIL restart%0d: got index=%0d level=%0d flags=%b, want 0/1/10000", r, index, level, flags);
      else passed++;
    end
    press(4'b0001);
    press(4'b0100);
    total++;
    if (flags !== 5'b01100) $display("FAIL restart_pass: got flags=%b, want 01100", flags);
    else passed++;
    tick();
    total++;
    if (level !== 2) $display("FAIL restart_level: got level=%0d, want 2", level);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_win();
    test_timeout();
    test_press_at_limit();
    test_reset_mid();
    test_start_with_press();
    test_idle_ignore();
    test_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simon_seq_checker.md
Name: simon_seq_checker

Overview:
- Parametrised next-generation Simon input checker. It compares a stream of player button presses against a stored pattern, one symbol per press, and reports the round result.
- Round length is derived internally from the level counter: length = level+1.
- Adds a per-press timeout, an explicit valid handshake, a win condition at MAX_LEN, and a current-index output for the display.
- Sits between the debounced button/encoder front end and the game controller, which owns pattern generation and playback.

Parameters:
- SYM_W, 4, width of one symbol (one-hot button code or encoded value; compared bit-exact).
- MAX_LEN, 10, maximum pattern length; completing a round of this length is a win.
- LEN_W, $clog2(MAX_LEN+1), width of level and index.
- TIMEOUT_CYC, 0, clock cycles allowed between presses; 0 disables the timeout.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins checking a round at index 0.
- pattern  in  MAX_LEN*SYM_W  packed pattern; symbol k occupies bits [k*SYM_W +: SYM_W]. Held stable by the controller during a round.
- in_valid  in  1  one-cycle pulse; a press is present on in_sym.
- in_sym  in  SYM_W  pressed symbol.
- busy  out  1  high in WAIT_IN.
- index  out  LEN_W  position of the next expected symbol.
- level  out  LEN_W  number of rounds completed in the current game.
- result_valid  out  1  one-cycle pulse carrying the round result.
- result_correct  out  1  qualifies result_valid; 1 = round passed.
- game_over  out  1  one-cycle pulse on a wrong press or a timeout.
- win  out  1  one-cycle pulse on completion of a MAX_LEN round.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - state=IDLE; index=0; level=0; timer=0.
  - All outputs 0.
  - Reset overrides every other input, including mid-round.
- States: IDLE, WAIT_IN, PASS, FAIL, WIN.
- IDLE:
  - start -> WAIT_IN, index=0, timer cleared.
  - in_valid is ignored.
- WAIT_IN, on in_valid:
  - Compare in_sym to pattern symbol[index].
  - Mismatch -> FAIL.
  - Match with index==level and level==MAX_LEN-1 -> WIN.
  - Match with index==level otherwise -> PASS.
  - Match otherwise -> index+1, stay in WAIT_IN, timer cleared.
- WAIT_IN, without in_valid:
  - timer increments.
  - With TIMEOUT_CYC>0 and timer==TIMEOUT_CYC-1 -> FAIL.
  - A press arriving in that same cycle wins over the timeout and is evaluated normally.
- start while in WAIT_IN: aborts the round; index=0, timer=0, level unchanged, no result emitted.
- start together with in_valid: start wins and the press is discarded.
- PASS (one cycle):
  - result_valid=1, result_correct=1.
  - Next edge: level+1, index=0, state -> IDLE.
- FAIL (one cycle):
  - result_valid=1, result_correct=0, game_over=1.
  - Next edge: level=0, index=0, state -> IDLE.
- WIN (one cycle):
  - result_valid=1, result_correct=1, win=1.
  - Next edge: level=0, index=0, state -> IDLE.
- start arriving in PASS, FAIL or WIN is ignored; the controller must wait for IDLE.
- Outputs are decoded from the registered state (Moore), so there are no combinational paths from inputs to outputs.
- Latency: a decisive press sampled at edge N produces result_valid high during cycle N+1 (the cycle after edge N).
- Widths:
  - index never exceeds level.
  - level never exceeds MAX_LEN-1, so it does not wrap.
  - The timer is wide enough for TIMEOUT_CYC and saturates when the timeout is disabled.
- Symbols at positions above level are don't-care.

Decomposition:
- Package simon_pkg:
  - state enum (IDLE, WAIT_IN, PASS, FAIL, WIN).
  - symbol-slice helper function.
  - default parameter constants shared with the game controller and pattern generator.
- Sub-module simon_timeout_timer:
  - Ports: clear, enable, expire; parameter TIMEOUT_CYC.
  - Contains the saturating counter and the disable-at-0 logic.
- The checker FSM, index counter and level counter remain in simon_seq_checker.

Test Plan (SYM_W=4, MAX_LEN=4, TIMEOUT_CYC=8, pattern symbols 0..3 = 0001, 0100, 0010, 1000):
- Reset, start, press 0001 -> result_valid and result_correct pulse one cycle after the press; level goes 0->1; busy falls.
- At level=1: start, press 0001 then 1000 -> result_valid=1, result_correct=0, game_over=1; level returns to 0.
- Play rounds for level 0..3 with correct presses -> final round emits win=1 and result_correct=1; level returns to 0; no PASS pulse on the final round.
- start, then idle 8 cycles with no press -> game_over at cycle 8.
- start, then press on exactly cycle 7 -> press evaluated; no timeout.
- Mid-round (index=1 at level=2): assert resetn=0 -> next cycle index=0, level=0, all outputs 0.
- Mid-round: assert start together with in_valid -> index=0; no result emitted.
- In IDLE: in_valid presses -> ignored.
- In WAIT_IN: start repeated -> index=0, level unchanged, no result.
